// File: rtl/alu_pkg.sv
// Operation codes, legality check and sequencer state encoding shared by the
// ALU and every block that drives it.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr_q, with
// the pointer moving past the winner only when the caller commits the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx
);

  localparam int IW = $clog2(N);

  logic [2:0] ptr_q, ptr_d;

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[IW'(idx)]) begin
        found           = 1'b1;
        grant[IW'(idx)] = 1'b1;
        grant_idx       = 3'(idx);
      end
    end
  end

  assign ptr_d = 3'((int'(grant_idx) + 1) % N);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between NREQ requesters: accept pulse, one ALU
// drive cycle, then a registered response; illegal ops are answered with an error.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [2:0]        alu_ctrl,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_zero,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [2:0]        rsp_id
);

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant;
  logic [2:0]      grant_idx;
  logic            do_grant;
  logic            op_legal;
  logic [2:0]      op_sel;
  logic [W-1:0]    a_sel, b_sel;

  logic [2:0]      op_q, id_q;
  logic [W-1:0]    a_q, b_q;

  logic [NREQ-1:0] req_ready_q, rsp_valid_q;
  logic [2:0]      alu_ctrl_q, rsp_id_q;
  logic [W-1:0]    alu_a_q, alu_b_q, rsp_data_q;
  logic            rsp_zero_q, rsp_err_q;

  // Requests are sampled only outside the accept cycle, where the winner still holds valid.
  assign do_grant = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (|req_valid);
  assign op_legal = op_is_legal(op_q);

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (do_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op_sel = req_op[3*i +: 3];
        a_sel  = req_a[W*i +: W];
        b_sel  = req_b[W*i +: W];
      end
    end
  end

  // ST_EXEC is the accept cycle; ST_DONE is the cycle the ALU is driven and sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (do_grant) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = do_grant ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= '0;
      alu_ctrl_q  <= OP_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= do_grant ? grant : '0;
      if ((state_q == ST_EXEC) && op_legal) begin
        alu_ctrl_q <= op_q;
        alu_a_q    <= a_q;
        alu_b_q    <= b_q;
      end else begin
        alu_ctrl_q <= OP_ADD;
        alu_a_q    <= '0;
        alu_b_q    <= '0;
      end
      rsp_valid_q <= '0;
      if (state_q == ST_DONE) begin
        rsp_valid_q <= NREQ'(1) << id_q;
        rsp_data_q  <= op_legal ? alu_out : '0;
        rsp_zero_q  <= op_legal & alu_zero;
        rsp_err_q   <= ~op_legal;
        rsp_id_q    <= id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_grant) begin
      op_q <= op_sel;
      a_q  <= a_sel;
      b_q  <= b_sel;
      id_q <= grant_idx;
    end
  end

  assign req_ready = req_ready_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;

endmodule
